rv_ext_mem_bridge: RTL and testbench
====================================

// Module: rv_ext_mem_bridge
// PURPOSE
//  External-host access bridge for the RV32I core's instruction and data memories. Replaces
//  reset-gated external write muxing with a valid/ready host port. Two access modes:
//   - LOAD:  bulk load with the CPU held.
//   - STEAL: cycle-stealing reads/writes while the CPU runs, via bounded Stall insertion.
//  Sits between riscv_cpu and instr_mem/data_mem in the top level.
// PARAMETERS
//  ADDR_W     32  address width, host and memory side
//  DATA_W     32  data width
//  MAX_BURST  4   max consecutive STEAL accesses before one forced CPU cycle (1..15)
//  CNT_W      16  width of load word counter
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       synchronous, active-high
//  load_mode   in   1       1 = request LOAD mode (CPU held, bulk load)
//  ext_valid   in   1       host request valid
//  ext_ready   out  1       request accepted this cycle (valid&ready = transfer)
//  ext_we      in   1       1 = write, 0 = read
//  ext_sel     in   1       0 = data mem, 1 = instr mem
//  ext_addr    in   ADDR_W  byte address
//  ext_wdata   in   DATA_W  write data
//  ext_rvalid  out  1       read data valid (1-cycle pulse)
//  ext_rdata   out  DATA_W  read data, held until next read
//  ext_err     out  1       1-cycle pulse: rejected access
//  cpu_memwrite in  1       CPU data-port write enable
//  cpu_adr     in   ADDR_W  CPU data address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_stall   out  1       freeze CPU (PC and memory write)
//  cpu_hold    out  1       hold CPU in reset (OR'd with reset at top)
//  dmem_we     out  1       data-mem write enable
//  dmem_adr    out  ADDR_W  data-mem address
//  dmem_wdata  out  DATA_W  data-mem write data
//  dmem_rdata  in   DATA_W  data-mem combinational read data
//  imem_we     out  1       instr-mem write enable
//  imem_adr    out  ADDR_W  instr-mem host-side address
//  imem_wdata  out  DATA_W  instr-mem write data
//  imem_rdata  in   DATA_W  instr-mem host-side combinational read data
//  load_count  out  CNT_W   words written in current/last LOAD session
// BEHAVIOUR
//  States: RUN, STEAL, GAP, LOAD. Reset -> RUN; ext_rdata=0, load_count=0, burst cnt=0.
//   All pulse outputs 0. Reset mid-access drops any pending ext_rvalid.
//  RUN:   CPU owns dmem (dmem_* = cpu_*). cpu_stall=0, cpu_hold=0, ext_ready=0.
//    load_mode=1 -> LOAD (takes priority); else ext_valid=1 -> STEAL.
//  STEAL: cpu_stall=1; dmem muxed to host; ext_ready=1 when ext_valid; 1 access/cycle.
//    burst cnt++ per transfer. Exit on !ext_valid -> RUN, or on burst cnt==MAX_BURST -> GAP.
//    Host must keep ext_valid/addr/we/wdata stable until ext_ready.
//  GAP:   exactly 1 cycle, cpu_stall=0, ext_ready=0, burst cnt cleared -> RUN.
//    Guarantees the CPU one instruction per MAX_BURST stolen cycles.
//  LOAD:  cpu_hold=1, cpu_stall=1, ext_ready=ext_valid. load_count cleared on LOAD entry.
//    load_count++ per write transfer; saturates at all-ones.
//    load_mode=0 -> RUN next cycle; cpu_hold falls with the state change.
//  Writes: dmem_we/imem_we = 1 in the transfer cycle only; address/data pass through.
//  Reads: ext_rdata <= (ext_sel ? imem_rdata : dmem_rdata) at the transfer edge.
//    ext_rvalid=1 the following cycle (latency 1). Back-to-back reads pipeline 1/cycle.
//  ext_sel=1 write outside LOAD: accepted (ext_ready=1), no memory write, ext_err=1 next cycle.
//  imem reads allowed in both modes.
//  load_mode rising during STEAL: finish current transfer, then -> LOAD (skips GAP).
// TESTING
//  1. reset=1 for 2 clks with ext_valid=1 -> ext_ready=0, ext_rvalid=0, dmem_we=0,
//     load_count=0, cpu_stall=0.
//  2. LOAD; 8 imem writes 0x0,0x4..0x1C -> imem_we pulses x8, load_count=8,
//     cpu_hold=1 throughout, 0 one cycle after load_mode falls.
//  3. RUN, host read dmem 0x100 (dmem holds 0xDEADBEEF) -> cpu_stall=1 for 1 cycle,
//     ext_rvalid next cycle with ext_rdata=0xDEADBEEF.
//  4. RUN, 10 back-to-back dmem writes, MAX_BURST=4 -> stall pattern 1111 0 1111 0 11,
//     all 10 words in dmem.
//  5. RUN, imem write 0x40 -> ext_ready=1, imem_we=0, ext_err pulse; imem contents unchanged.
//  6. reset asserted in the cycle after a STEAL read transfer -> ext_rvalid stays 0,
//     state RUN, cpu_stall=0.

Source files
------------

// File: rtl/rv_ext_mem_bridge.sv
// rv_ext_mem_bridge: valid/ready host access to the RV32I instr/data memories.
// LOAD holds the CPU for bulk loading; STEAL borrows bounded CPU stall cycles.
module rv_ext_mem_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic              ext_sel,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_err,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_hold,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_adr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_adr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [CNT_W-1:0]  load_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STEAL = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam logic [3:0] BMAX = 4'(MAX_BURST);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [3:0]        r_burst;
  logic [3:0]        w_burst_inc;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic [CNT_W-1:0]  r_load_count;

  logic w_load;
  logic w_steal;
  logic w_host;
  logic w_xfer;
  logic w_wr;
  logic w_rd;
  logic w_imem_wr;
  logic w_dmem_wr;
  logic w_bad_wr;

  // The CPU is only stalled in STEAL while the host actually presents a
  // request; once the host lets go the CPU resumes the same cycle.
  assign w_load    = (r_state == S_LOAD);
  assign w_steal   = (r_state == S_STEAL) && ext_valid;
  assign w_host    = w_load || w_steal;
  assign w_xfer    = w_host && ext_valid && !reset;
  assign w_wr      = w_xfer && ext_we;
  assign w_rd      = w_xfer && !ext_we;
  assign w_imem_wr = w_wr && ext_sel && w_load;
  assign w_bad_wr  = w_wr && ext_sel && !w_load;
  assign w_dmem_wr = w_wr && !ext_sel;

  assign w_burst_inc = 4'(r_burst + 4'd1);

  assign ext_ready  = w_xfer;
  assign ext_rvalid = r_rvalid && !reset;
  assign ext_rdata  = r_rdata;
  assign ext_err    = r_err && !reset;
  assign cpu_stall  = w_host && !reset;
  assign cpu_hold   = w_load && !reset;

  assign dmem_we    = w_host ? w_dmem_wr : (cpu_memwrite && !reset);
  assign dmem_adr   = w_host ? ext_addr  : cpu_adr;
  assign dmem_wdata = w_host ? ext_wdata : cpu_wdata;

  assign imem_we    = w_imem_wr;
  assign imem_adr   = ext_addr;
  assign imem_wdata = ext_wdata;

  assign load_count = r_load_count;

  // Next state; GAP gives the CPU its cycle, then re-arbitrates like RUN
  // so a sustained host burst alternates MAX_BURST steals with one CPU cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN, S_GAP: begin
        if (load_mode)      w_next = S_LOAD;
        else if (ext_valid) w_next = S_STEAL;
        else                w_next = S_RUN;
      end
      S_STEAL: begin
        if (load_mode)                 w_next = S_LOAD;
        else if (!ext_valid)           w_next = S_RUN;
        else if (w_burst_inc == BMAX)  w_next = S_GAP;
        else                           w_next = S_STEAL;
      end
      S_LOAD: begin
        if (!load_mode) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  // State register and consecutive-steal counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != S_STEAL)
        r_burst <= '0;
      else if (w_xfer)
        r_burst <= w_burst_inc;
    end
  end

  // Read data capture, read-valid and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_err    <= w_bad_wr;
      if (w_rd)
        r_rdata <= ext_sel ? imem_rdata : dmem_rdata;
    end
  end

  // Words written per LOAD session, cleared on entry, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_count <= '0;
    end else if (w_next == S_LOAD && !w_load) begin
      r_load_count <= '0;
    end else if (w_load && w_wr && r_load_count != '1) begin
      r_load_count <= r_load_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_ext_mem_bridge.sv
// tb_rv_ext_mem_bridge: directed + random host traffic against a
// memory-level reference model of the bridge.
module tb_rv_ext_mem_bridge;
  localparam int MB = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset, load_mode, ext_valid, ext_we, ext_sel;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic ext_ready, ext_rvalid, ext_err;
  logic cpu_memwrite, cpu_stall, cpu_hold;
  logic [31:0] cpu_adr, cpu_wdata;
  logic dmem_we, imem_we;
  logic [31:0] dmem_adr, dmem_wdata, dmem_rdata;
  logic [31:0] imem_adr, imem_wdata, imem_rdata;
  logic [CW-1:0] load_count;

  always #5 clk = ~clk;

  rv_ext_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(MB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .load_mode(load_mode),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we),
    .ext_sel(ext_sel), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_hold(cpu_hold),
    .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .imem_we(imem_we), .imem_adr(imem_adr),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .load_count(load_count)
  );

  // Memories seen by the bridge
  logic [31:0] dmem [0:255] = '{default: 32'h0};
  logic [31:0] imem [0:255] = '{default: 32'h0};
  always @(posedge clk) if (dmem_we) dmem[dmem_adr[9:2]] <= dmem_wdata;
  always @(posedge clk) if (imem_we) imem[imem_adr[9:2]] <= imem_wdata;
  assign dmem_rdata = dmem[dmem_adr[9:2]];
  assign imem_rdata = imem[imem_adr[9:2]];

  // Reference model state
  logic [31:0] exp_d [0:255] = '{default: 32'h0};
  logic [31:0] exp_i [0:255] = '{default: 32'h0};
  logic [31:0] exp_rd [$];
  int exp_errs, exp_iwe, exp_lwr;
  bit in_load;
  int lm_at;

  // Host op table
  logic        op_we   [32];
  logic        op_sel  [32];
  logic [31:0] op_addr [32];
  logic [31:0] op_wd   [32];

  // Monitor, sampled on the falling edge
  logic [31:0] got_rd [$];
  logic        stall_q [$];
  int n_err_m = 0, n_iwe_m = 0, n_hold_drop = 0;
  bit rec, watch_hold;
  always @(negedge clk) begin
    if (ext_rvalid) got_rd.push_back(ext_rdata);
    if (ext_err) n_err_m++;
    if (imem_we) n_iwe_m++;
    if (rec) stall_q.push_back(cpu_stall);
    if (watch_hold && !cpu_hold) n_hold_drop++;
  end

  int n_tot = 0, n_pass = 0;
  int rd_base = 0, st_base = 0;
  int err_base, iwe_base, hd_base;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic model(input int i);
    int a;
    a = int'(op_addr[i][9:2]);
    if (op_we[i]) begin
      if (!op_sel[i]) exp_d[a] = op_wd[i];
      else if (in_load) begin exp_i[a] = op_wd[i]; exp_iwe++; end
      else exp_errs++;
      if (in_load) exp_lwr++;
    end else begin
      exp_rd.push_back(op_sel[i] ? exp_i[a] : exp_d[a]);
    end
  endtask

  task automatic run_ops(input int n, input string tag);
    int i, budget;
    logic rdy;
    i = 0;
    budget = 0;
    rec = 1;
    @(posedge clk); #1;
    while (i < n && budget < 200) begin
      if (i == lm_at) load_mode = 1'b1;
      ext_valid = 1'b1;
      ext_we    = op_we[i];
      ext_sel   = op_sel[i];
      ext_addr  = op_addr[i];
      ext_wdata = op_wd[i];
      @(negedge clk);
      rdy = ext_ready;
      @(posedge clk); #1;
      if (rdy) begin
        model(i);
        i++;
      end
      budget++;
    end
    ext_valid = 1'b0;
    rec = 0;
    check({tag, "_done"}, i, n);
  endtask

  task automatic check_reads(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_nrd"}, got_rd.size() - rd_base, exp_rd.size());
    for (int j = 0; j < exp_rd.size(); j++)
      if (rd_base + j < got_rd.size())
        check({tag, "_rd"}, got_rd[rd_base + j], exp_rd[j]);
    rd_base = got_rd.size();
    exp_rd.delete();
  endtask

  task automatic check_pat(input string tag, input int n, input bit gaps);
    logic [63:0] ev, gv;
    int el, gl, f, l;
    ev = '0; el = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && k % MB == 0) begin
        ev = {ev[62:0], 1'b0}; el++;
      end
      ev = {ev[62:0], 1'b1}; el++;
    end
    f = -1; l = -1;
    for (int k = st_base; k < stall_q.size(); k++)
      if (stall_q[k]) begin
        if (f < 0) f = k;
        l = k;
      end
    gv = '0; gl = 0;
    if (f >= 0)
      for (int k = f; k <= l; k++) begin
        gv = {gv[62:0], stall_q[k]}; gl++;
      end
    st_base = stall_q.size();
    check({tag, "_plen"}, gl, el);
    check({tag, "_pbits"}, gv, ev);
  endtask

  task automatic wr_op(input int k, input logic sel, input logic [31:0] a);
    op_we[k] = 1'b1; op_sel[k] = sel; op_addr[k] = a; op_wd[k] = $urandom;
  endtask

  task automatic rd_op(input int k, input logic sel, input logic [31:0] a);
    op_we[k] = 1'b0; op_sel[k] = sel; op_addr[k] = a; op_wd[k] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nw, cap;
    reset = 1; load_mode = 0; ext_valid = 1; ext_we = 0; ext_sel = 0;
    ext_addr = 0; ext_wdata = 0;
    cpu_memwrite = 0; cpu_adr = 0; cpu_wdata = 0;
    rec = 0; watch_hold = 0; in_load = 0; lm_at = -1;
    exp_errs = 0; exp_iwe = 0; exp_lwr = 0;

    // 1: reset held two cycles with a request pending
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", ext_ready, 0);
      check("rst_rvalid", ext_rvalid, 0);
      check("rst_dmem_we", dmem_we, 0);
      check("rst_lcnt", load_count, 0);
      check("rst_stall", cpu_stall, 0);
    end
    @(posedge clk); #1;
    reset = 0; ext_valid = 0;

    // CPU owns dmem in RUN: preload 0x100 through the CPU port
    cpu_memwrite = 1; cpu_adr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("run_dmem_we", dmem_we, 1);
    check("run_dmem_adr", dmem_adr, 32'h100);
    check("run_stall", cpu_stall, 0);
    @(posedge clk); #1;
    cpu_memwrite = 0;
    exp_d[8'h40] = 32'hDEADBEEF;

    // 2: LOAD session, 8 imem writes plus an imem read
    load_mode = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("load_hold", cpu_hold, 1);
    check("load_stall", cpu_stall, 1);
    for (int k = 0; k < 8; k++) wr_op(k, 1'b1, 32'(4 * k));
    rd_op(8, 1'b1, 32'h8);
    in_load = 1; exp_lwr = 0;
    iwe_base = n_iwe_m; hd_base = n_hold_drop;
    watch_hold = 1;
    run_ops(9, "load8");
    load_mode = 0;
    @(negedge clk);
    check("load_hold_last", cpu_hold, 1);
    watch_hold = 0;
    in_load = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("load_hold_off", cpu_hold, 0);
    check("load_cnt8", load_count, 8);
    check("load_iwe8", n_iwe_m - iwe_base, 8);
    check("load_hold_drops", n_hold_drop - hd_base, 0);
    for (int k = 0; k < 8; k++) check("load_imem", imem[k], exp_i[k]);
    check_reads("load8");
    st_base = stall_q.size();

    // 3: single steal read of 0x100
    rd_op(0, 1'b0, 32'h100);
    run_ops(1, "rd1");
    @(negedge clk);
    check("rd1_rvalid", ext_rvalid, 1);
    check("rd1_rdata", ext_rdata, 32'hDEADBEEF);
    check("rd1_stall_off", cpu_stall, 0);
    check_pat("rd1", 1, 1'b1);
    check_reads("rd1");
    check("rd1_hold", ext_rdata, 32'hDEADBEEF);

    // 4: ten back-to-back dmem writes, then read them back
    for (int k = 0; k < 10; k++) wr_op(k, 1'b0, 32'h300 + 32'(4 * k));
    run_ops(10, "wr10");
    check_pat("wr10", 10, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 10; k++)
      check("wr10_dmem", dmem[8'hC0 + k], exp_d[8'hC0 + k]);
    for (int k = 0; k < 10; k++) rd_op(k, 1'b0, 32'h300 + 32'(4 * k));
    run_ops(10, "rd10");
    check_pat("rd10", 10, 1'b1);
    check_reads("rd10");

    // 5: imem write outside LOAD is rejected
    err_base = n_err_m; iwe_base = n_iwe_m; exp_errs = 0;
    wr_op(0, 1'b1, 32'h40);
    run_ops(1, "iwr");
    repeat (2) @(negedge clk);
    check("iwr_err", n_err_m - err_base, 1);
    check("iwr_iwe", n_iwe_m - iwe_base, 0);
    check("iwr_imem", imem[8'h10], exp_i[8'h10]);
    st_base = stall_q.size();

    // Random steal traffic
    err_base = n_err_m; iwe_base = n_iwe_m; exp_errs = 0;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1)
        wr_op(k, 1'($urandom_range(0, 3) == 0),
              32'h200 + 32'(4 * $urandom_range(0, 15)));
      else if ($urandom_range(0, 1) == 1)
        rd_op(k, 1'b1, 32'(4 * $urandom_range(0, 7)));
      else
        rd_op(k, 1'b0, 32'h200 + 32'(4 * $urandom_range(0, 15)));
    end
    run_ops(24, "rs");
    check_reads("rs");
    check("rs_err", n_err_m - err_base, exp_errs);
    check("rs_iwe", n_iwe_m - iwe_base, 0);
    check("rs_lcnt", load_count, 8);
    for (int k = 0; k < 16; k++)
      check("rs_dmem", dmem[8'h80 + k], exp_d[8'h80 + k]);
    st_base = stall_q.size();

    // Random LOAD session reaching counter saturation
    load_mode = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rl_cnt_clr", load_count, 0);
    for (int k = 0; k < 24; k++) begin
      if (k < 16 || $urandom_range(0, 1) == 1)
        wr_op(k, 1'($urandom_range(0, 1)),
              32'h280 + 32'(4 * $urandom_range(0, 15)));
      else
        rd_op(k, 1'($urandom_range(0, 1)),
              32'h280 + 32'(4 * $urandom_range(0, 15)));
    end
    in_load = 1; exp_lwr = 0; exp_iwe = 0; iwe_base = n_iwe_m;
    run_ops(24, "rl");
    load_mode = 0;
    in_load = 0;
    nw = exp_lwr;
    cap = (nw > 15) ? 15 : nw;
    repeat (2) @(posedge clk);
    #1;
    check("rl_lcnt_sat", load_count, cap);
    check("rl_iwe", n_iwe_m - iwe_base, exp_iwe);
    check("rl_hold_off", cpu_hold, 0);
    for (int k = 0; k < 16; k++) begin
      check("rl_dmem", dmem[8'hA0 + k], exp_d[8'hA0 + k]);
      check("rl_imem", imem[8'hA0 + k], exp_i[8'hA0 + k]);
    end
    check_reads("rl");
    st_base = stall_q.size();

    // load_mode rising mid-burst: no GAP, later writes counted
    for (int k = 0; k < 6; k++) wr_op(k, 1'b0, 32'h380 + 32'(4 * k));
    lm_at = 2;
    run_ops(6, "lms");
    lm_at = -1;
    check_pat("lms", 6, 1'b0);
    @(negedge clk);
    check("lms_hold", cpu_hold, 1);
    check("lms_lcnt", load_count, 3);
    @(posedge clk); #1;
    load_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("lms_hold_off", cpu_hold, 0);
    for (int k = 0; k < 6; k++)
      check("lms_dmem", dmem[8'hE0 + k], exp_d[8'hE0 + k]);

    // 6: reset right after a steal read transfer
    rd_base = got_rd.size();
    @(posedge clk); #1;
    ext_valid = 1; ext_we = 0; ext_sel = 0; ext_addr = 32'h100;
    begin
      int b;
      b = 0;
      @(negedge clk);
      while (!ext_ready && b < 20) begin
        @(negedge clk);
        b++;
      end
      check("r6_ready", ext_ready, 1);
    end
    @(posedge clk); #1;
    ext_valid = 0; reset = 1;
    @(negedge clk);
    check("r6_rvalid_rst", ext_rvalid, 0);
    @(posedge clk); #1;
    reset = 0; ext_valid = 1;
    @(negedge clk);
    check("r6_rvalid", ext_rvalid, 0);
    check("r6_stall", cpu_stall, 0);
    check("r6_ready_run", ext_ready, 0);
    check("r6_lcnt", load_count, 0);
    check("r6_rdata", ext_rdata, 0);
    check("r6_nrd", got_rd.size() - rd_base, 0);
    @(posedge clk); #1;
    ext_valid = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
